cpu_data_bus_bridge: RTL
========================

// Module: cpu_data_bus_bridge
// PURPOSE
//  Data-side slave for the pipelined CPU's load/store bus (addr/wdata/wmask/wen/ren/done).
//  Decodes each access to a local word-addressed data RAM, an external peripheral port, or unmapped space.
//  Returns read data with a bus_done pulse.
//  Sits directly downstream of the CPU EX/WB memory path. Supplies bus_rdata/bus_done consumed by WB.
// PARAMETERS
//  RAM_SIZE_W     4096          data RAM depth in 32-bit words; power of 2
//  RAM_BASE       32'h0000_0000 byte base of RAM region; region spans RAM_SIZE_W*4 bytes
//  PERIPH_BASE    32'h8000_0000 byte base of peripheral region
//  PERIPH_SIZE    32'h1000_0000 byte span of peripheral region
//  TIMEOUT_CYCLES 255           peripheral wait limit; used only with BUS_TIMEOUT_EN
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  bus_addr      in   32  byte address; word index = addr[31:2]
//  bus_wdata     in   32  write data, already lane-aligned by CPU
//  bus_wmask     in   4   byte write enables
//  bus_wen       in   1   write request
//  bus_ren       in   1   read request
//  bus_rdata     out  32  full read word; valid in the bus_done cycle
//  bus_done      out  1   one-cycle completion pulse per accepted request
//  bus_err       out  1   sticky error flag; cleared only by rst
//  periph_addr   out  32  registered request address
//  periph_wdata  out  32  registered write data
//  periph_wmask  out  4   registered mask
//  periph_wen    out  1   peripheral request is a write
//  periph_valid  out  1   peripheral request valid; held until ready
//  periph_ready  in   1   peripheral accept/complete
//  periph_rdata  in   32  peripheral read data; valid with periph_ready
// BEHAVIOUR
//  - Reset: state=IDLE, bus_done=0, bus_rdata=0, bus_err=0, periph_valid=0, periph_wen=0,
//    periph_addr/wdata/wmask=0. RAM contents are not cleared.
//    rst mid-access abandons the access; no bus_done is issued for it.
//  - Master rule: request signals are held stable until bus_done is sampled high.
//    The master updates or drops them at that edge.
//  - Accept: request accepted in IDLE when (bus_ren|bus_wen).
//    If both are asserted, the access is treated as a write and bus_err is set.
//  - FSM: IDLE -> RAM_RESP | PER_WAIT | UNM_RESP. Each *_RESP state drives bus_done=1 for exactly
//    one cycle, then returns to IDLE. A new request can be accepted the cycle after bus_done.
//  - RAM region, hit = addr in [RAM_BASE, RAM_BASE+RAM_SIZE_W*4):
//    - Accept edge: read registers mem[idx]; write updates bytes where wmask[i]=1.
//    - Next cycle (RAM_RESP): bus_done=1 with bus_rdata = word read.
//    - Write: bus_rdata = 0.
//    - Latency is 1 cycle, and the read is synchronous BRAM style.
//  - Peripheral region, hit = addr in [PERIPH_BASE, PERIPH_BASE+PERIPH_SIZE):
//    - Accept edge: latch addr/wdata/wmask/wen into periph_*; periph_valid=1 from the next cycle.
//    - In PER_WAIT, on the edge where periph_valid&periph_ready:
//      - periph_valid <= 0;
//      - bus_rdata <= wen ? 0 : periph_rdata;
//      - go to a one-cycle response with bus_done=1.
//    - Minimum latency is 2 cycles: accept -> PER_WAIT with ready=1 -> done.
//    - periph_ready is ignored while periph_valid=0.
//  - Unmapped: bus_done next cycle, bus_rdata=0, write dropped, bus_err<=1.
//  - Region compare uses full 32-bit unsigned arithmetic. The upper bound is exclusive.
//    Base+size overflow wraps to 0, meaning "to top of address space".
//  - bus_rdata holds its last value outside bus_done cycles. bus_done is never high in IDLE.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - An 8..32-bit counter clears on entering PER_WAIT and increments each PER_WAIT cycle.
//   - When it reaches TIMEOUT_CYCLES with no ready: periph_valid<=0, bus_rdata<=32'hDEAD_BEEF,
//     bus_err<=1, and bus_done=1 next cycle.
//   - A ready arriving in the same cycle as expiry wins: it is a normal completion with no error.
//  BUS_TIMEOUT_EN undefined: no counter; PER_WAIT waits for periph_ready indefinitely.
//   TIMEOUT_CYCLES is unused.
// TESTING
//  1 RAM: write 0x1234_5678 mask 4'hF @0x10, then mask 4'b0100 data 0x00AB_0000 @0x10, read @0x10
//    -> rdata 0x12AB_5678; each done exactly 1 cycle after accept.
//  2 Periph read @0x8000_0004, ready asserted 3 cycles after valid, rdata 0xCAFE_F00D
//    -> periph_valid held 4 cycles, bus_done 1 cycle later with 0xCAFE_F00D, err=0.
//  3 Unmapped read @0x4000_0000 -> done next cycle, rdata 0, bus_err=1 and stays 1 until rst.
//  4 ren&wen together @0x20 with wdata 0x55 -> RAM word 0x20 = 0x55, bus_err=1.
//  5 rst in PER_WAIT (valid high) -> next cycle periph_valid=0, no bus_done, RAM @0x10 still 0x12AB_5678.
//  6 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, periph_ready stuck 0
//    -> done with 0xDEAD_BEEF, bus_err=1; without the macro, no done after 1000 cycles.

Source files
------------

// File: rtl/cpu_data_bus_bridge_if.sv
// CPU data-side load/store bus between the pipeline (master) and the data bus bridge (slave).
interface cpu_data_bus_bridge_if;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_wen;
   logic        bus_ren;
   logic [31:0] bus_rdata;
   logic        bus_done;
   logic        bus_err;

   modport master (
      output bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren,
      input  bus_rdata, bus_done, bus_err
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren,
      output bus_rdata, bus_done, bus_err
   );
endinterface

// File: rtl/cpu_data_bus_bridge.sv
// Data-side bus slave: decodes CPU loads/stores to local word RAM, a peripheral port, or unmapped space.
// Optional BUS_TIMEOUT_EN macro bounds the peripheral wait to TIMEOUT_CYCLES cycles.
module cpu_data_bus_bridge #(
   parameter int unsigned RAM_SIZE_W     = 4096,
   parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
   parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
   parameter logic [31:0] PERIPH_SIZE    = 32'h1000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   cpu_data_bus_bridge_if.slave  bus,
   output logic [31:0]           periph_addr,
   output logic [31:0]           periph_wdata,
   output logic [3:0]            periph_wmask,
   output logic                  periph_wen,
   output logic                  periph_valid,
   input  logic                  periph_ready,
   input  logic [31:0]           periph_rdata
);
   localparam int unsigned AW       = $clog2(RAM_SIZE_W);
   localparam logic [31:0] RAM_SPAN = 32'(RAM_SIZE_W * 4);

   typedef enum logic [2:0] {IDLE, RAM_RESP, PER_WAIT, PER_RESP, UNM_RESP} state_t;
   state_t state, state_nxt;

   logic [31:0]   mem [RAM_SIZE_W];
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          done_c;
   logic          req, ram_hit, per_hit, per_fire, tmo_fire;
   logic [AW-1:0] ram_idx;

   // Upper bound is exclusive; a base+span that wraps to 0 means "up to the top of memory".
   function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                      input logic [31:0] span);
      logic [31:0] lim;
      lim = base + span;
      return (a >= base) && ((lim == '0) || (a < lim));
   endfunction

   always_comb begin
      req      = bus.bus_ren | bus.bus_wen;
      ram_hit  = in_region(bus.bus_addr, RAM_BASE, RAM_SPAN);
      per_hit  = !ram_hit && in_region(bus.bus_addr, PERIPH_BASE, PERIPH_SIZE);
      ram_idx  = AW'((bus.bus_addr - RAM_BASE) >> 2);
      per_fire = (state == PER_WAIT) && periph_valid && periph_ready;
   end

`ifdef BUS_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   // Ready in the expiry cycle wins, so expiry is masked by per_fire.
   assign tmo_fire = (state == PER_WAIT) && !per_fire && (tmo_cnt >= TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (rst || state != PER_WAIT) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + 32'd1;
   end
`else
   logic [31:0] unused_timeout_cycles;
   assign unused_timeout_cycles = TIMEOUT_CYCLES;
   assign tmo_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (ram_hit)      state_nxt = RAM_RESP;
               else if (per_hit) state_nxt = PER_WAIT;
               else              state_nxt = UNM_RESP;
            end
         end
         PER_WAIT: if (per_fire || tmo_fire) state_nxt = PER_RESP;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      done_c = (state == RAM_RESP) || (state == PER_RESP) || (state == UNM_RESP);
   end

   assign bus.bus_done  = done_c;
   assign bus.bus_rdata = rdata_q;
   assign bus.bus_err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q      <= '0;
         err_q        <= 1'b0;
         periph_addr  <= '0;
         periph_wdata <= '0;
         periph_wmask <= '0;
         periph_wen   <= 1'b0;
         periph_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (bus.bus_ren && bus.bus_wen) err_q <= 1'b1;
                  if (ram_hit) begin
                     rdata_q <= bus.bus_wen ? '0 : mem[ram_idx];
                  end else if (per_hit) begin
                     periph_addr  <= bus.bus_addr;
                     periph_wdata <= bus.bus_wdata;
                     periph_wmask <= bus.bus_wmask;
                     periph_wen   <= bus.bus_wen;
                     periph_valid <= 1'b1;
                  end else begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            PER_WAIT: begin
               if (per_fire) begin
                  periph_valid <= 1'b0;
                  rdata_q      <= periph_wen ? '0 : periph_rdata;
               end else if (tmo_fire) begin
                  periph_valid <= 1'b0;
                  rdata_q      <= 32'hDEAD_BEEF;
                  err_q        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM is not reset; a write whose accept edge coincides with rst is abandoned.
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && req && ram_hit && bus.bus_wen) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.bus_wmask[i]) mem[ram_idx][8*i +: 8] <= bus.bus_wdata[8*i +: 8];
         end
      end
   end
endmodule
